// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (fetch/data) single-port memory arbiter
// Data wins by default; a bounded streak of contended data grants lets fetch through.
module mem_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [31:0]     if_instr_o,
  input  logic            flush_i,
  input  logic            d_req_i,
  input  logic [XLEN-1:0] d_adr_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_wdata_i,
  input  logic [2:0]      d_size_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  state_t     state_q, state_d;
  logic       owner_q;
  logic       drop_q;
  logic [3:0] streak_q;
  logic       data_win, fetch_win, rsp_take;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (data_win || fetch_win) state_d = REQ;
      REQ:      if (mem_gnt_i)             state_d = WAIT_RSP;
      WAIT_RSP: if (mem_rvalid_i)          state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Grants are suppressed while reset is held so a master never sees an accept that is thrown away.
  always_comb begin
    data_win  = 1'b0;
    fetch_win = 1'b0;
    if (state_q == IDLE && !reset) begin
      data_win  = d_req_i && !(if_req_i && streak_q == STREAK_MAX);
      fetch_win = if_req_i && !data_win;
    end
    if_gnt_o  = fetch_win;
    d_gnt_o   = data_win;
    mem_req_o = (state_q == REQ);
    busy_o    = (state_q != IDLE);
    rsp_take  = (state_q == WAIT_RSP) && mem_rvalid_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= 1'b0;
      drop_q      <= 1'b0;
      streak_q    <= '0;
      mem_adr_o   <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
      mem_size_o  <= '0;
      if_rvalid_o <= 1'b0;
      if_instr_o  <= '0;
      d_rvalid_o  <= 1'b0;
      d_rdata_o   <= '0;
    end else begin
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
      if (data_win) begin
        mem_adr_o   <= d_adr_i;
        mem_we_o    <= d_we_i;
        mem_wdata_o <= d_wdata_i;
        mem_size_o  <= d_size_i;
        owner_q     <= 1'b1;
        drop_q      <= 1'b0;
        if (!if_req_i)                   streak_q <= '0;
        else if (streak_q < STREAK_MAX)  streak_q <= streak_q + 4'd1;
      end else if (fetch_win) begin
        mem_adr_o   <= if_adr_i;
        mem_we_o    <= 1'b0;
        mem_wdata_o <= '0;
        mem_size_o  <= 3'b010;
        owner_q     <= 1'b0;
        drop_q      <= flush_i;
        streak_q    <= '0;
      end
      if (state_q != IDLE && !owner_q && flush_i) drop_q <= 1'b1;
      // A flush in the response cycle itself still discards the fetch.
      if (rsp_take) begin
        drop_q <= 1'b0;
        if (owner_q) begin
          d_rdata_o  <= mem_rdata_i;
          d_rvalid_o <= 1'b1;
        end else if (!(drop_q || flush_i)) begin
          if_instr_o  <= mem_rdata_i[31:0];
          if_rvalid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Transaction-level reference model plus directed literal checks and random traffic.
module tb_mem_arbiter;
  localparam int XLEN = 32;
  localparam int MAXS = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            if_req_i = 1'b0;
  logic [31:0]     if_adr_i = '0;
  logic            if_gnt_o, if_rvalid_o;
  logic [31:0]     if_instr_o;
  logic            flush_i = 1'b0;
  logic            d_req_i = 1'b0;
  logic [31:0]     d_adr_i = '0;
  logic            d_we_i = 1'b0;
  logic [31:0]     d_wdata_i = '0;
  logic [2:0]      d_size_i = '0;
  logic            d_gnt_o, d_rvalid_o;
  logic [31:0]     d_rdata_o;
  logic            mem_req_o, mem_we_o;
  logic [31:0]     mem_adr_o, mem_wdata_o;
  logic [2:0]      mem_size_o;
  logic            mem_gnt_i = 1'b0;
  logic            mem_rvalid_i = 1'b0;
  logic [31:0]     mem_rdata_i = '0;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.XLEN(XLEN), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_instr_o(if_instr_o), .flush_i(flush_i),
    .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
    .d_size_i(d_size_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference model: one outstanding transaction record, advanced once per cycle.
  bit          started = 0;
  bit          m_busy, m_acc, m_owner, m_drop, m_we;
  logic [31:0] m_adr, m_wdata;
  logic [2:0]  m_size;
  int          m_streak;
  bit          e_ifv, e_dv;
  logic [31:0] e_instr, e_rdata;

  always @(negedge clk) begin : compare
    bit egd, egf;
    egd = !reset && !m_busy && d_req_i && !(if_req_i && m_streak == MAXS);
    egf = !reset && !m_busy && if_req_i && !egd;
    if (started) begin
      chk1("d_gnt", d_gnt_o, egd);
      chk1("if_gnt", if_gnt_o, egf);
      chk1("busy", busy_o, m_busy);
      chk1("mem_req", mem_req_o, m_busy && !m_acc);
      chk32("mem_adr", mem_adr_o, m_adr);
      chk1("mem_we", mem_we_o, m_we);
      chk32("mem_wdata", mem_wdata_o, m_wdata);
      chk32("mem_size", 32'(mem_size_o), 32'(m_size));
      chk1("if_rvalid", if_rvalid_o, e_ifv);
      chk1("d_rvalid", d_rvalid_o, e_dv);
      if (e_ifv) chk32("if_instr", if_instr_o, e_instr);
      if (e_dv)  chk32("d_rdata", d_rdata_o, e_rdata);
    end
    e_ifv = 0;
    e_dv  = 0;
    if (reset) begin
      started = 1;
      m_busy = 0; m_acc = 0; m_owner = 0; m_drop = 0; m_we = 0;
      m_adr = '0; m_wdata = '0; m_size = '0; m_streak = 0;
      e_instr = '0; e_rdata = '0;
    end else if (started) begin
      if (!m_busy) begin
        if (egd) begin
          m_busy = 1; m_acc = 0; m_owner = 1; m_drop = 0;
          m_adr = d_adr_i; m_we = d_we_i; m_wdata = d_wdata_i; m_size = d_size_i;
          m_streak = if_req_i ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else if (egf) begin
          m_busy = 1; m_acc = 0; m_owner = 0; m_drop = flush_i;
          m_adr = if_adr_i; m_we = 0; m_wdata = '0; m_size = 3'd2;
          m_streak = 0;
        end
      end else begin
        if (!m_owner && flush_i) m_drop = 1;
        if (!m_acc) begin
          if (mem_gnt_i) m_acc = 1;
        end else if (mem_rvalid_i) begin
          if (m_owner) begin
            e_dv = 1; e_rdata = mem_rdata_i;
          end else if (!m_drop) begin
            e_ifv = 1; e_instr = mem_rdata_i;
          end
          m_busy = 0;
        end
      end
    end
  end

  initial begin : stim
    byte   got[$];
    string exp_order;
    int    both;
    bit    g_if, g_d, was_reset;

    repeat (2) cyc();
    reset = 1'b0;
    #1;
    chk1("reset busy", busy_o, 1'b0);
    chk1("reset mem_req", mem_req_o, 1'b0);
    chk1("reset if_rvalid", if_rvalid_o, 1'b0);

    // Single fetch, best-case latency.
    if_req_i = 1'b1; if_adr_i = 32'h8000_0000;
    #1;
    chk1("t1 if_gnt c0", if_gnt_o, 1'b1);
    chk1("t1 d_gnt c0", d_gnt_o, 1'b0);
    cyc(); if_req_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    chk1("t1 mem_req c1", mem_req_o, 1'b1);
    chk32("t1 mem_adr c1", mem_adr_o, 32'h8000_0000);
    chk32("t1 mem_size c1", 32'(mem_size_o), 32'd2);
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0050_0093;
    cyc(); mem_rvalid_i = 1'b0;
    #1;
    chk1("t1 if_rvalid c3", if_rvalid_o, 1'b1);
    chk32("t1 if_instr c3", if_instr_o, 32'h0050_0093);
    chk1("t1 busy c3", busy_o, 1'b0);

    // Continuous contention: data streak of 4 then one fetch.
    exp_order = "DDDDFDDDDF";
    both = 0;
    if_req_i = 1'b1; d_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int n = 0; n < 60 && got.size() < 10; n++) begin
      #1;
      if (d_gnt_o && if_gnt_o) both++;
      if (d_gnt_o)  got.push_back(8'h44);
      if (if_gnt_o) got.push_back(8'h46);
      cyc();
      if_adr_i = $urandom; d_adr_i = $urandom;
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    chk32("t2 double grants", 32'(both), 32'd0);
    if (got.size() < 10) begin
      errors++; checks++;
      $display("FAIL t2 grant timeout actual=%0d required=10", got.size());
    end else begin
      for (int i = 0; i < 10; i++)
        chk32($sformatf("t2 grant %0d", i), 32'(got[i]), 32'(exp_order[i]));
    end
    repeat (3) cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    cyc();

    // Store with the memory grant withheld for three cycles.
    d_req_i = 1'b1; d_we_i = 1'b1; d_adr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF; d_size_i = 3'd2;
    #1;
    chk1("t3 d_gnt", d_gnt_o, 1'b1);
    cyc(); d_req_i = 1'b0; d_we_i = 1'b0; d_adr_i = '0; d_wdata_i = '0; d_size_i = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1($sformatf("t3 mem_req %0d", i), mem_req_o, 1'b1);
      chk32($sformatf("t3 mem_adr %0d", i), mem_adr_o, 32'h100);
      chk32($sformatf("t3 mem_wdata %0d", i), mem_wdata_o, 32'hDEAD_BEEF);
      chk1($sformatf("t3 mem_we %0d", i), mem_we_o, 1'b1);
      chk32($sformatf("t3 mem_size %0d", i), 32'(mem_size_o), 32'd2);
      cyc();
    end
    mem_gnt_i = 1'b1;
    cyc(); mem_gnt_i = 1'b0;
    cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A_5A5A;
    cyc(); mem_rvalid_i = 1'b0;
    #1;
    chk1("t3 d_rvalid", d_rvalid_o, 1'b1);
    chk1("t3 if_rvalid", if_rvalid_o, 1'b0);
    cyc();
    #1;
    chk1("t3 d_rvalid pulse", d_rvalid_o, 1'b0);

    // Fetch flushed in WAIT_RSP, then a normal fetch.
    if_req_i = 1'b1; if_adr_i = 32'h200;
    #1;
    chk1("t4 if_gnt a", if_gnt_o, 1'b1);
    cyc(); if_req_i = 1'b0; mem_gnt_i = 1'b1;
    cyc(); mem_gnt_i = 1'b0; flush_i = 1'b1;
    cyc(); flush_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
    cyc(); mem_rvalid_i = 1'b0;
    #1;
    chk1("t4 dropped if_rvalid", if_rvalid_o, 1'b0);
    chk1("t4 busy after drop", busy_o, 1'b0);
    if_req_i = 1'b1; if_adr_i = 32'h204;
    #1;
    chk1("t4 if_gnt b", if_gnt_o, 1'b1);
    cyc(); if_req_i = 1'b0; mem_gnt_i = 1'b1;
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2222_2222;
    cyc(); mem_rvalid_i = 1'b0;
    #1;
    chk1("t4 if_rvalid b", if_rvalid_o, 1'b1);
    chk32("t4 if_instr b", if_instr_o, 32'h2222_2222);

    // Reset during WAIT_RSP with the response in the reset cycle.
    cyc();
    d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = 32'h300; d_size_i = 3'd2;
    #1;
    chk1("t5 d_gnt", d_gnt_o, 1'b1);
    cyc(); d_req_i = 1'b0; mem_gnt_i = 1'b1;
    cyc(); mem_gnt_i = 1'b0; reset = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3333_3333;
    cyc(); reset = 1'b0; mem_rvalid_i = 1'b0; if_req_i = 1'b1; if_adr_i = 32'h400;
    #1;
    chk1("t5 d_rvalid", d_rvalid_o, 1'b0);
    chk1("t5 if_rvalid", if_rvalid_o, 1'b0);
    chk1("t5 busy", busy_o, 1'b0);
    chk1("t5 mem_req", mem_req_o, 1'b0);
    chk32("t5 mem_adr", mem_adr_o, 32'h0);
    chk32("t5 d_rdata", d_rdata_o, 32'h0);
    chk32("t5 if_instr", if_instr_o, 32'h0);
    chk1("t5 fresh if_gnt", if_gnt_o, 1'b1);
    cyc(); if_req_i = 1'b0; mem_gnt_i = 1'b1;
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h4444_4444;
    cyc(); mem_rvalid_i = 1'b0;
    #1;
    chk1("t5 if_rvalid after", if_rvalid_o, 1'b1);
    chk32("t5 if_instr after", if_instr_o, 32'h4444_4444);

    // Random traffic; masters hold requests until granted.
    g_if = 0; g_d = 0; was_reset = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (!if_req_i || g_if || was_reset) begin
        if_req_i = ($urandom_range(0, 3) != 0);
        if_adr_i = $urandom;
      end
      if (!d_req_i || g_d || was_reset) begin
        d_req_i   = ($urandom_range(0, 2) != 0);
        d_adr_i   = $urandom;
        d_we_i    = 1'($urandom_range(0, 1));
        d_wdata_i = $urandom;
        d_size_i  = 3'($urandom_range(0, 7));
      end
      mem_gnt_i    = 1'($urandom_range(0, 1));
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_rdata_i  = $urandom;
      flush_i      = ($urandom_range(0, 7) == 0);
      reset        = ($urandom_range(0, 249) == 0);
      #1;
      g_if = if_gnt_o;
      g_d  = d_gnt_o;
      was_reset = reset;
    end
    cyc();
    if_req_i = 1'b0; d_req_i = 1'b0; flush_i = 1'b0; reset = 1'b0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    repeat (4) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
